// File: rtl/vram_fill_ctrl.sv
// Parametrised video RAM with a region-fill engine; host writes pre-empt (pause) the fill.
// Define FILL_BYPASS_EN for write-to-read forwarding; otherwise reads return the old value.
module vram_fill_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int DEPTH = 38400
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_rq,
  input  logic [AW-1:0] fill_start,
  input  logic [AW-1:0] fill_len,
  input  logic [DW-1:0] fill_val,
  output logic          fill_busy,
  output logic          fill_ack,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_we,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // state | meaning
  // IDLE  | waiting for fill_rq; latches start/len/val on request
  // FILL  | writes val at cur each cycle the host port is quiet
  // DONE  | one-cycle fill_ack, then back to IDLE
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cur, cur_nxt;
  logic [AW-1:0] remain, remain_nxt;
  logic [DW-1:0] val, val_nxt;
  logic          fill_we;
  logic          host_we;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    remain_nxt = remain;
    val_nxt    = val;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_rq) begin
          cur_nxt    = fill_start;
          remain_nxt = fill_len;
          val_nxt    = fill_val;
          state_nxt  = (fill_len == '0 || fill_start > LAST) ? DONE : FILL;
        end
      end
      FILL: begin
        if (!wr_we) begin
          fill_we    = 1'b1;
          cur_nxt    = cur + AW'(1);
          remain_nxt = remain - AW'(1);
          // clip at the last entry; never wrap back to address 0
          if (remain == AW'(1) || cur == LAST) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      remain    <= '0;
      val       <= '0;
      fill_busy <= 1'b0;
      fill_ack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      remain    <= remain_nxt;
      val       <= val_nxt;
      fill_busy <= (state_nxt != IDLE);
      fill_ack  <= (state_nxt == DONE);
    end
  end

  // single write port: host has priority, the fill only uses idle host cycles
  assign host_we  = wr_we && (wr_addr <= LAST);
  assign mem_we   = host_we || fill_we;
  assign mem_addr = wr_we ? wr_addr : cur;
  assign mem_din  = wr_we ? wr_data : val;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk) begin
`ifdef FILL_BYPASS_EN
    if (mem_we && mem_addr == rd_addr) rd_data <= mem_din;
    else if (rd_addr <= LAST)          rd_data <= mem[rd_addr];
`else
    if (rd_addr <= LAST) rd_data <= mem[rd_addr];
`endif
  end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Self-checking bench for vram_fill_ctrl: reference memory model plus a read scoreboard queue.
module tb_vram_fill_ctrl;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int DEPTH = 38400;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_rq;
  logic [AW-1:0] fill_start;
  logic [AW-1:0] fill_len;
  logic [DW-1:0] fill_val;
  logic          fill_busy;
  logic          fill_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            addr_q [$];

  vram_fill_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fill_rq(fill_rq), .fill_start(fill_start), .fill_len(fill_len), .fill_val(fill_val),
    .fill_busy(fill_busy), .fill_ack(fill_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_addr = a[AW-1:0];
      exp_q.push_back(model[a]);
      addr_q.push_back(a);
      @(posedge clk); #1;
      check($sformatf("rd@%0d", addr_q.pop_front()), {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    wr_addr = a[AW-1:0];
    wr_data = d;
    wr_we   = 1'b1;
    if (a < DEPTH) model[a] = d;
    @(posedge clk); #1;
    wr_we = 1'b0;
  endtask

  // request held until ack; inputs scrambled while busy to prove they were latched
  task automatic do_fill(input string tag, input int start, input int len, input logic [DW-1:0] v,
                         input int p_at, input int p_n, input int p_addr, input logic [DW-1:0] p_data,
                         input int exp_ack);
    int cyc = 0;
    int busy_cyc = 0;
    bit got = 0;
    fill_start = start[AW-1:0];
    fill_len   = len[AW-1:0];
    fill_val   = v;
    fill_rq    = 1'b1;
    if (len > 0 && start < DEPTH)
      for (int i = start; i < start + len && i < DEPTH; i++) model[i] = v;
    while (!got && cyc < DEPTH + 200) begin
      @(posedge clk); #1;
      cyc++;
      fill_start = ~start[AW-1:0];
      fill_len   = 16'h00FF;
      fill_val   = ~v;
      if (fill_busy) busy_cyc++;
      if (fill_ack) begin
        got = 1;
        fill_rq = 1'b0;
      end
      wr_we = !got && (cyc >= p_at) && (cyc < p_at + p_n);
      wr_addr = p_addr[AW-1:0];
      wr_data = p_data;
      if (wr_we && p_addr < DEPTH) model[p_addr] = p_data;
    end
    wr_we = 1'b0;
    fill_rq = 1'b0;
    check({tag, "_ack_seen"}, {31'h0, got}, 32'd1);
    check({tag, "_ack_cycle"}, cyc, exp_ack);
    check({tag, "_busy_cycles"}, busy_cyc, exp_ack);
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, {31'h0, fill_ack}, 32'd0);
    check({tag, "_busy_low"}, {31'h0, fill_busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fill_rq = 1'b0; fill_start = '0; fill_len = '0; fill_val = '0;
    wr_addr = '0; wr_data = '0; wr_we = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, fill_busy}, 32'd0);
    check("rst_ack", {31'h0, fill_ack}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", {31'h0, fill_busy}, 32'd0);

    do_fill("clear", 0, DEPTH, 8'h00, 0, 0, 0, 8'h00, DEPTH + 1);
    read_range(0, 0);
    read_range(19200, 19200);
    read_range(DEPTH - 1, DEPTH - 1);

    host_write(100, 8'h5A);
    read_range(100, 100);
    do_fill("f98", 98, 4, 8'hFF, 0, 0, 0, 8'h00, 5);
    read_range(97, 102);

    do_fill("pause", 200, 10, 8'h11, 4, 3, 5, 8'h77, 14);
    read_range(5, 5);
    read_range(199, 210);

    do_fill("clip", DEPTH - 2, 10, 8'hAB, 0, 0, 0, 8'h00, 3);
    read_range(DEPTH - 4, DEPTH - 1);
    read_range(0, 0);

    do_fill("len0", 300, 0, 8'hEE, 0, 0, 0, 8'h00, 1);
    read_range(299, 301);
    do_fill("oob", 40000, 5, 8'hEE, 0, 0, 0, 8'h00, 1);

    host_write(40000, 8'h42);
    read_range(1600, 1600);

    fill_start = '0; fill_len = 16'd1000; fill_val = 8'h3C; fill_rq = 1'b1;
    @(posedge clk); #1;
    fill_rq = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_pre", {31'h0, fill_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, fill_busy}, 32'd0);
    check("abort_ack", {31'h0, fill_ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) model[i] = 8'h3C;
    read_range(0, 11);
    @(posedge clk); #1;
    check("post_abort_ack", {31'h0, fill_ack}, 32'd0);

    wr_addr = 16'd500; wr_data = 8'h99; wr_we = 1'b1; rd_addr = 16'd500;
`ifdef FILL_BYPASS_EN
    exp_q.push_back(8'h99);
`else
    exp_q.push_back(model[500]);
`endif
    addr_q.push_back(500);
    model[500] = 8'h99;
    @(posedge clk); #1;
    wr_we = 1'b0;
    check($sformatf("same_cycle_rd@%0d", addr_q.pop_front()), {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
    read_range(500, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_fill_ctrl.md
Name: vram_fill_ctrl

Overview:
- Parametrised video RAM with a built-in region-fill engine.
- Generalises the fixed 8-bit, 38400-entry, clear-to-zero frame buffer:
  - configurable data width and depth;
  - fill of an arbitrary address range with an arbitrary value;
  - host writes have priority and pause the fill instead of being lost.
- Sits between the CPU-side video write bus and the VGA scan-out read port.

Parameters:
DW, 8, data width of one pixel entry
AW, 16, address width of all address ports
DEPTH, 38400, number of entries; valid addresses 0..DEPTH-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
fill_rq  in  1  fill request, level, sampled only in IDLE
fill_start  in  AW  first address to fill, latched with request
fill_len  in  AW  number of entries to fill, latched with request
fill_val  in  DW  fill value, latched with request
fill_busy  out  1  engine active (state != IDLE)
fill_ack  out  1  one-cycle completion pulse
wr_addr  in  AW  host write address
wr_data  in  DW  host write data
wr_we  in  1  host write enable
rd_addr  in  AW  scan-out read address
rd_data  out  DW  registered read data

Behaviour:
- Reset (async on rst high):
  - state=IDLE; fill_busy=0; fill_ack=0; internal cur/remain=0.
  - Memory contents are not reset. rd_data is not reset; it is undefined until the first read.
- Read port: rd_data <= mem[rd_addr] every clk, 1-cycle latency.
  - Read of address >= DEPTH returns an undefined value and has no side effects.
  - Same-cycle write and read of the same address: rd_data returns the OLD value, unless FILL_BYPASS_EN is defined (see Optional Feature).
- Host writes: wr_we=1 with wr_addr < DEPTH writes wr_data at the edge. wr_addr >= DEPTH is ignored.
- Write-port arbitration:
  - Host wr_we always wins.
  - The fill engine writes only in cycles where wr_we=0.
  - No host write is ever dropped.
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - fill_rq=1 latches cur=fill_start, remain=fill_len, val=fill_val.
    - If fill_len==0 or fill_start>=DEPTH -> DONE, with no memory writes.
    - Otherwise -> FILL.
  - FILL, each cycle with wr_we=0:
    - mem[cur]<=val; cur<=cur+1; remain<=remain-1.
    - If remain==1 or cur==DEPTH-1 -> DONE. The range is clipped at DEPTH-1; there is no wrap to 0.
  - FILL, cycle with wr_we=1: no fill write, counters hold (pause).
  - DONE: fill_ack=1 for exactly this cycle -> IDLE.
- fill_busy = (state != IDLE), registered with the state.
- Latency, uncontended fill of N>0 entries:
  - rq sampled at edge 0;
  - fill writes at edges 1..N;
  - ack high in the cycle after edge N;
  - busy low after edge N+1.
- Each host write during FILL adds one cycle of latency.
- Requester rules:
  - The requester must drop fill_rq on seeing fill_ack. A level still high when the FSM is back in IDLE starts a new fill.
  - fill_rq while busy is ignored. Latched parameters do not change mid-fill.
- Address arithmetic is AW bits wide. start+len overflow is irrelevant because the clip at DEPTH-1 terminates first.
- rst asserted mid-fill: FSM aborts immediately to IDLE, busy=0, no ack. Entries already written keep their values.

Optional Feature:
- Macro: FILL_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If the effective write (host or fill) targets rd_addr in the same cycle, rd_data takes the written value at that edge.
  - Adds one comparator and one mux.
- Undefined: read-before-write semantics (old value). Block maps to plain simple-dual-port BRAM.

Test Plan:
- Reset then fill_rq with start=0, len=DEPTH, val=8'h00, no host writes:
  - busy for DEPTH+1 cycles; ack single pulse at cycle DEPTH+1;
  - reads of 0, 19200, 38399 return 8'h00.
- Host write 8'h5A @100, then fill start=98, len=4, val=8'hFF:
  - 98..101 read 8'hFF; 97 and 102 unchanged;
  - ack at cycle 5 after request.
- Fill start=200, len=10, val=8'h11, with host wr_we=1 @addr 5 data 8'h77 for 3 cycles mid-fill:
  - ack delayed by exactly 3 cycles (cycle 14);
  - addr 5=8'h77; 200..209=8'h11.
- Fill start=38398, len=10, val=8'hAB:
  - only 38398 and 38399 written;
  - ack after 2 writes; addr 0 unchanged.
- Fill len=0:
  - ack one cycle after request; no memory change;
  - fill_rq held high during busy is ignored.
- rst pulsed mid-fill (start=0, len=1000, after 10 writes):
  - busy=0 and ack=0 immediately;
  - 0..9 hold the fill value; 10 unchanged;
  - with FILL_BYPASS_EN, a same-address read during write returns the new data.
